blinker_tick_gen: RTL

- Parametrised successor of the single-period blinker counter.
- One enable-gated counter wraps at a runtime-programmable period instead of free-running at 2^WIDTH.
- Drives a one-cycle tick, a 50 % toggle output and CHANNELS independent PWM outputs.
- Sits between the board clock domain (system1000) and the LED/indicator pins; other blocks use tick_o as a slow strobe.

---
 rtl/blinker_pkg.sv | 19 +
 rtl/blinker_tick_gen_if.sv | 32 +++
 rtl/blinker_pwm_cmp.sv | 50 +++++
 rtl/blinker_tick_gen.sv | 105 ++++++++++
 4 files changed

// File: rtl/blinker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : blinker_pkg
// Purpose  : Shared defaults and the effective-period helper for blinker_tick_gen.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package blinker_pkg;

    localparam int BLINKER_WIDTH          = 26;
    localparam int BLINKER_CHANNELS       = 4;
    localparam int BLINKER_DEFAULT_PERIOD = 50 * 1024 * 1024;

    // A programmed period of zero behaves as a period of one.
    function automatic logic [31:0] blinker_eff_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blinker_tick_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : blinker_tick_gen_if
// Purpose  : Control/status bundle between a host and blinker_tick_gen.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface blinker_tick_gen_if
    import blinker_pkg::*;
#(
    parameter int WIDTH    = BLINKER_WIDTH,
    parameter int CHANNELS = BLINKER_CHANNELS
);
    logic                      en_i;
    logic                      load_i;
    logic [WIDTH-1:0]          period_i;
    logic [CHANNELS*WIDTH-1:0] duty_i;
    logic [WIDTH-1:0]          count_o;
    logic                      tick_o;
    logic                      toggle_o;
    logic [CHANNELS-1:0]       pwm_o;

    modport master (
        output en_i, load_i, period_i, duty_i,
        input  count_o, tick_o, toggle_o, pwm_o
    );

    modport slave (
        input  en_i, load_i, period_i, duty_i,
        output count_o, tick_o, toggle_o, pwm_o
    );
endinterface
`default_nettype wire

// File: rtl/blinker_pwm_cmp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : blinker_pwm_cmp
// Purpose  : One PWM channel: shadow/active duty pair and registered compare.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module blinker_pwm_cmp
    import blinker_pkg::*;
#(
    parameter int WIDTH        = BLINKER_WIDTH,
    parameter int DEFAULT_DUTY = BLINKER_DEFAULT_PERIOD / 2
) (
    input  wire logic             system1000,
    input  wire logic             system1000_rstn,
    input  wire logic             i_clear,
    input  wire logic             i_load,
    input  wire logic             i_wrap,
    input  wire logic             i_pending,
    input  wire logic [WIDTH-1:0] i_duty,
    input  wire logic [WIDTH-1:0] i_count,
    output logic                  o_pwm
);
    localparam logic [WIDTH-1:0] c_default_duty = WIDTH'(DEFAULT_DUTY);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_pwm;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_shadow <= c_default_duty;
            r_active <= c_default_duty;
            r_pwm    <= 1'b0;
        end else begin
            // A load coinciding with a wrap goes straight to the active copy.
            if (i_load && i_wrap) begin
                r_active <= i_duty;
            end else if (i_load) begin
                r_shadow <= i_duty;
            end else if (i_wrap && i_pending) begin
                r_active <= r_shadow;
            end
            r_pwm <= !i_clear && (i_count < r_active);
        end
    end

    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/blinker_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : blinker_tick_gen
// Purpose  : Programmable-period counter with tick, toggle and CHANNELS PWM
//            outputs. Optional synchronous clear_i via BLINKER_SYNC_CLEAR_EN.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module blinker_tick_gen
    import blinker_pkg::*;
#(
    parameter int WIDTH          = BLINKER_WIDTH,
    parameter int CHANNELS       = BLINKER_CHANNELS,
    parameter int DEFAULT_PERIOD = BLINKER_DEFAULT_PERIOD
) (
    input  wire logic         system1000,
    input  wire logic         system1000_rstn,
`ifdef BLINKER_SYNC_CLEAR_EN
    input  wire logic         clear_i,
`endif
    blinker_tick_gen_if.slave bus
);
    localparam logic [WIDTH-1:0] c_default_period = WIDTH'(DEFAULT_PERIOD);

    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    r_period;
    logic [WIDTH-1:0]    r_shadow_period;
    logic                r_pending;
    logic                r_tick;
    logic                r_toggle;
    logic                w_clear;
    logic                w_wrap;
    logic [WIDTH-1:0]    w_eff_period;
    logic [CHANNELS-1:0] w_pwm;

`ifdef BLINKER_SYNC_CLEAR_EN
    assign w_clear = clear_i;
`else
    assign w_clear = 1'b0;
`endif

    assign w_eff_period = WIDTH'(blinker_eff_period(32'(r_period)));
    assign w_wrap       = bus.en_i && !w_clear && (r_count == w_eff_period - WIDTH'(1));

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_count  <= '0;
            r_tick   <= 1'b0;
            r_toggle <= 1'b0;
        end else if (w_clear) begin
            r_count  <= '0;
            r_tick   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            if (bus.en_i) begin
                r_count <= w_wrap ? '0 : r_count + WIDTH'(1);
            end
            r_tick   <= w_wrap;
            r_toggle <= r_toggle ^ w_wrap;
        end
    end

    // Period changes only at a wrap, so the new period always starts at count 0.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_period        <= c_default_period;
            r_shadow_period <= c_default_period;
            r_pending       <= 1'b0;
        end else if (bus.load_i && w_wrap) begin
            r_period  <= bus.period_i;
            r_pending <= 1'b0;
        end else if (bus.load_i) begin
            r_shadow_period <= bus.period_i;
            r_pending       <= 1'b1;
        end else if (w_wrap && r_pending) begin
            r_period  <= r_shadow_period;
            r_pending <= 1'b0;
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_pwm
            blinker_pwm_cmp #(
                .WIDTH        (WIDTH),
                .DEFAULT_DUTY (DEFAULT_PERIOD / 2)
            ) u_cmp (
                .system1000      (system1000),
                .system1000_rstn (system1000_rstn),
                .i_clear         (w_clear),
                .i_load          (bus.load_i),
                .i_wrap          (w_wrap),
                .i_pending       (r_pending),
                .i_duty          (bus.duty_i[c*WIDTH +: WIDTH]),
                .i_count         (r_count),
                .o_pwm           (w_pwm[c])
            );
        end
    endgenerate

    assign bus.count_o  = r_count;
    assign bus.tick_o   = r_tick;
    assign bus.toggle_o = r_toggle;
    assign bus.pwm_o    = w_pwm;

endmodule
`default_nettype wire
